// File: rtl/fc_stream_neuron.sv
// Streaming FP32 fully-connected neuron: per-beat multiply, registered adder tree,
// bias-first accumulation across beats and an optional ReLU on the handshaked result.
module fc_stream_neuron #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 16,
    parameter int NUM_BEATS  = 4,
    parameter int RELU_EN    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH*LANES-1:0] in_data,
    input  logic [DATA_WIDTH*LANES-1:0] in_weight,
    input  logic [DATA_WIDTH-1:0]       bias,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        busy
);
    localparam int LOG = $clog2(LANES);
    localparam int BW  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int DW  = $clog2(LOG + 2) + 1;

    localparam logic [1:0] ST_ACCEPT = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_OUT    = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic                  accept, beat_first, beat_last;
    logic [DATA_WIDTH-1:0] bias_q, bias_d, acc_q, acc_d, out_q, out_d;
    logic [DATA_WIDTH-1:0] partial, add_a, add_b, add_y;
    logic                  acc_last_q, acc_last_d;

    assign in_ready   = (state_q == ST_ACCEPT);
    assign out_valid  = (state_q == ST_OUT);
    assign busy       = (beat_q != '0) || (state_q != ST_ACCEPT);
    assign out_data   = out_q;
    assign accept     = in_valid & in_ready;
    assign beat_first = (beat_q == '0);
    assign beat_last  = (beat_q == BW'(NUM_BEATS - 1));

    // The drain window is sized so OUT is entered on the same edge the result register loads.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        case (state_q)
            ST_ACCEPT: begin
                if (accept) begin
                    if (beat_last) begin
                        beat_d  = '0;
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == DW'(LOG + 1)) state_d = ST_OUT;
                else                         drain_d = drain_q + 1'b1;
            end
            ST_OUT: begin
                if (out_ready) state_d = ST_ACCEPT;
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi <= LOG; gi++) begin : g_lvl
            localparam int N = LANES >> gi;
            logic [DATA_WIDTH*N-1:0] val_q, val_d;
            logic                    tag_q, tag_d, first_q, first_d, last_q, last_d;

            if (gi == 0) begin : g_mul
                logic [DATA_WIDTH*N-1:0] prod_w;
                for (gj = 0; gj < N; gj++) begin : g_lane
                    Mul u_mul (
                        .a(in_data[DATA_WIDTH*gj +: DATA_WIDTH]),
                        .b(in_weight[DATA_WIDTH*gj +: DATA_WIDTH]),
                        .y(prod_w[DATA_WIDTH*gj +: DATA_WIDTH])
                    );
                end
                always_comb begin
                    val_d   = accept ? prod_w : val_q;
                    tag_d   = accept;
                    first_d = accept & beat_first;
                    last_d  = accept & beat_last;
                end
            end else begin : g_tree
                logic [DATA_WIDTH*N-1:0] sum_w;
                for (gj = 0; gj < N; gj++) begin : g_pair
                    Add_FP u_add (
                        .a(g_lvl[gi-1].val_q[DATA_WIDTH*(2*gj) +: DATA_WIDTH]),
                        .b(g_lvl[gi-1].val_q[DATA_WIDTH*(2*gj+1) +: DATA_WIDTH]),
                        .y(sum_w[DATA_WIDTH*gj +: DATA_WIDTH])
                    );
                end
                always_comb begin
                    val_d   = g_lvl[gi-1].tag_q ? sum_w : val_q;
                    tag_d   = g_lvl[gi-1].tag_q;
                    first_d = g_lvl[gi-1].first_q;
                    last_d  = g_lvl[gi-1].last_q;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    val_q   <= '0;
                    tag_q   <= 1'b0;
                    first_q <= 1'b0;
                    last_q  <= 1'b0;
                end else begin
                    val_q   <= val_d;
                    tag_q   <= tag_d;
                    first_q <= first_d;
                    last_q  <= last_d;
                end
            end
        end
    endgenerate

    assign partial = g_lvl[LOG].val_q[DATA_WIDTH-1:0];

    Add_FP u_acc (.a(add_a), .b(add_b), .y(add_y));

    // One adder serves both cases: bias joins the first partial, later partials join acc.
    always_comb begin
        add_a      = g_lvl[LOG].first_q ? partial : acc_q;
        add_b      = g_lvl[LOG].first_q ? bias_q : partial;
        acc_d      = g_lvl[LOG].tag_q ? add_y : acc_q;
        acc_last_d = g_lvl[LOG].tag_q & g_lvl[LOG].last_q;
        bias_d     = (accept & beat_first) ? bias : bias_q;
        out_d      = out_q;
        if (acc_last_q) begin
            out_d = ((RELU_EN != 0) && acc_q[DATA_WIDTH-1]) ? '0 : acc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ACCEPT;
            beat_q     <= '0;
            drain_q    <= '0;
            bias_q     <= '0;
            acc_q      <= '0;
            acc_last_q <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            drain_q    <= drain_d;
            bias_q     <= bias_d;
            acc_q      <= acc_d;
            acc_last_q <= acc_last_d;
            out_q      <= out_d;
        end
    end
endmodule

// Combinational FP32 multiply, round-to-nearest-even, subnormals flushed to zero.
module Mul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic              sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, s;
    logic [47:0]       prod;
    logic [22:0]       mant;
    logic [23:0]       rnd;
    logic signed [9:0] e_n, e_r;

    always_comb begin
        sgn    = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        prod   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e_n    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (prod[47]) begin
            mant = prod[46:24];
            g    = prod[23];
            s    = |prod[22:0];
            e_n  = e_n + 10'sd1;
        end else begin
            mant = prod[45:23];
            g    = prod[22];
            s    = |prod[21:0];
        end
        rnd = {1'b0, mant} + {23'd0, g & (s | mant[0])};
        e_r = e_n + $signed({9'd0, rnd[23]});
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) y = 32'h7FC00000;
        else if (a_inf || b_inf)                                      y = {sgn, 8'hFF, 23'd0};
        else if (a_zero || b_zero)                                    y = {sgn, 31'd0};
        else if (e_r >= 10'sd255)                                     y = {sgn, 8'hFF, 23'd0};
        else if (e_r <= 10'sd0)                                       y = {sgn, 31'd0};
        else                                                          y = {sgn, e_r[7:0], rnd[22:0]};
    end
endmodule

// Combinational FP32 add, round-to-nearest-even, subnormals flushed to zero.
module Add_FP (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic              a_big, a_nan, b_nan, a_inf, b_inf;
    logic [31:0]       x, z;
    logic [7:0]        ediff, dsh;
    logic [26:0]       mx, mz, mz_al;
    logic [53:0]       sh;
    logic [27:0]       sum;
    logic [25:0]       norm;
    logic [4:0]        msb;
    logic [23:0]       rnd;
    logic signed [9:0] e_n, e_r;

    always_comb begin
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == '0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == '0);
        a_big = (a[30:0] >= b[30:0]);
        x     = a_big ? a : b;
        z     = a_big ? b : a;
        mx    = {1'b1, x[22:0], 3'b000};
        mz    = (z[30:23] == 8'h00) ? 27'd0 : {1'b1, z[22:0], 3'b000};
        ediff = x[30:23] - z[30:23];
        dsh   = (ediff > 8'd27) ? 8'd27 : ediff;
        // Bits shifted out of the aligned operand collapse into a single sticky bit.
        sh    = {mz, 27'd0} >> dsh;
        mz_al = {sh[53:28], sh[27] | (|sh[26:0])};
        if (x[31] == z[31]) sum = {1'b0, mx} + {1'b0, mz_al};
        else                sum = {1'b0, mx} - {1'b0, mz_al};
        msb = 5'd0;
        for (int i = 0; i < 28; i++) begin
            if (sum[i]) msb = 5'(i);
        end
        if (msb == 5'd27) norm = {sum[26:2], sum[1] | sum[0]};
        else              norm = 26'(sum << (5'd26 - msb));
        e_n = $signed({2'b00, x[30:23]}) + $signed({5'd0, msb}) - 10'sd26;
        rnd = {1'b0, norm[25:3]} + {23'd0, norm[2] & (norm[3] | norm[1] | norm[0])};
        e_r = e_n + $signed({9'd0, rnd[23]});
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) y = 32'h7FC00000;
        else if (a_inf)                                             y = a;
        else if (b_inf)                                             y = b;
        else if (x[30:23] == 8'h00)                                 y = {a[31] & b[31], 31'd0};
        else if (sum == '0)                                         y = 32'h00000000;
        else if (e_r >= 10'sd255)                                   y = {x[31], 8'hFF, 23'd0};
        else if (e_r <= 10'sd0)                                     y = {x[31], 31'd0};
        else                                                        y = {x[31], e_r[7:0], rnd[22:0]};
    end
endmodule

// File: tb/tb_fc_stream_neuron.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop them on each output handshake.
module tb_fc_stream_neuron;
    localparam int LANES = 16;
    localparam logic [31:0] F_ONE  = 32'h3F800000;
    localparam logic [31:0] F_NONE = 32'hBF800000;
    localparam logic [31:0] F_TWO  = 32'h40000000;
    localparam logic [31:0] F_THR  = 32'h40400000;
    localparam logic [31:0] F_HALF = 32'h3F000000;
    localparam logic [31:0] F_HUND = 32'h42C80000;
    localparam logic [31:0] F_TEN  = 32'h41200000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [32*LANES-1:0] in_data = '0;
    logic [32*LANES-1:0] in_weight = '0;
    logic [31:0] bias = '0;
    logic in_ready_a, out_valid_a, busy_a, in_ready_b, out_valid_b, busy_b;
    logic [31:0] out_data_a, out_data_b;

    logic c_in_valid = 1'b0;
    logic c_out_ready = 1'b1;
    logic [31:0] c_in_data = '0;
    logic [31:0] c_in_weight = '0;
    logic [31:0] c_bias = '0;
    logic c_in_ready, c_out_valid, c_busy;
    logic [31:0] c_out_data;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [31:0] exp_c[$];

    always #5 clk = ~clk;

    fc_stream_neuron #(.DATA_WIDTH(32), .LANES(LANES), .NUM_BEATS(4), .RELU_EN(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_weight(in_weight), .bias(bias),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .busy(busy_a)
    );

    fc_stream_neuron #(.DATA_WIDTH(32), .LANES(LANES), .NUM_BEATS(4), .RELU_EN(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_weight(in_weight), .bias(bias),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .busy(busy_b)
    );

    fc_stream_neuron #(.DATA_WIDTH(32), .LANES(1), .NUM_BEATS(3), .RELU_EN(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_weight(c_in_weight), .bias(c_bias),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .busy(c_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", name, act, want);
        end else begin
            $display("ok   %s: got=%08h", name, act);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", name, act, want);
        end
    endtask

    // Drive one beat and return just after the edge that accepted it.
    task automatic send_beat(input logic [31:0] d, input logic [31:0] w, input logic [31:0] bs);
        int n;
        n = 0;
        in_data   = {LANES{d}};
        in_weight = {LANES{w}};
        bias      = bs;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready_a && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_a) check1("accept_timeout", in_ready_a, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check1("busy_after_beat", busy_a, 1'b1);
    endtask

    task automatic run_vec(input logic [31:0] d, input logic [31:0] w, input logic [31:0] b0,
                           input logic [31:0] bn, input int gap,
                           input logic [31:0] ea, input logic [31:0] eb);
        exp_a.push_back(ea);
        exp_b.push_back(eb);
        for (int b = 0; b < 4; b++) begin
            send_beat(d, w, (b == 0) ? b0 : bn);
            if (b < 3) repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check1("busy_drain", busy_a, 1'b1);
            check1((k < 6) ? "valid_early" : "valid_latency", out_valid_a, (k == 6));
        end
    endtask

    task automatic finish_hs();
        @(posedge clk);
        #1;
        check1("valid_cleared", out_valid_a, 1'b0);
        check1("ready_back", in_ready_a, 1'b1);
        check1("idle_after", busy_a, 1'b0);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid_a && out_ready) begin
                    if (exp_a.size() == 0) check1("spurious_a", out_valid_a, 1'b0);
                    else check("result_relu", out_data_a, exp_a.pop_front());
                end
                if (out_valid_b && out_ready) begin
                    if (exp_b.size() == 0) check1("spurious_b", out_valid_b, 1'b0);
                    else check("result_norelu", out_data_b, exp_b.pop_front());
                end
                if (c_out_valid && c_out_ready) begin
                    if (exp_c.size() == 0) check1("spurious_c", c_out_valid, 1'b0);
                    else check("result_lanes1", c_out_data, exp_c.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        #1 rst = 1'b1;
        #1;
        check1("rst_in_ready", in_ready_a, 1'b1);
        check1("rst_out_valid", out_valid_a, 1'b0);
        check("rst_out_data", out_data_a, 32'h00000000);
        check1("rst_busy", busy_a, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // basic: 16 * (1.0*2.0) per beat, four beats, bias 0.5
        run_vec(F_ONE, F_TWO, F_HALF, F_HALF, 0, 32'h43008000, 32'h43008000);
        finish_hs();

        // negative result: ReLU clamps, pass-through instance gives -64.0
        run_vec(F_ONE, F_NONE, 32'h0, 32'h0, 0, 32'h00000000, 32'hC2800000);
        finish_hs();

        // backpressure: 16 * 4.0 per beat, bias 0.5 -> 256.5, held for 10 cycles
        out_ready = 1'b0;
        run_vec(F_TWO, F_TWO, F_HALF, F_HALF, 0, 32'h43804000, 32'h43804000);
        in_data   = {LANES{F_HUND}};
        in_weight = {LANES{F_HUND}};
        in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check1("bp_valid", out_valid_a, 1'b1);
            check1("bp_in_ready", in_ready_a, 1'b0);
            check("bp_hold", out_data_a, 32'h43804000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        finish_hs();

        // gapped beats; later-beat bias must be ignored
        run_vec(F_ONE, F_TWO, F_HALF, F_HUND, 3, 32'h43008000, 32'h43008000);
        finish_hs();

        // reset in the middle of a vector discards it
        send_beat(F_ONE, F_ONE, 32'h0);
        send_beat(F_ONE, F_ONE, 32'h0);
        rst = 1'b1;
        #1;
        check1("mid_rst_in_ready", in_ready_a, 1'b1);
        check1("mid_rst_out_valid", out_valid_a, 1'b0);
        check("mid_rst_out_data", out_data_a, 32'h00000000);
        check1("mid_rst_busy", busy_a, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_vec(F_ONE, F_ONE, 32'h0, 32'h0, 0, 32'h42800000, 32'h42800000);
        finish_hs();

        // LANES=1, NUM_BEATS=3: 3 * (2.0*3.0) + 1.0 = 19.0
        exp_c.push_back(32'h41980000);
        for (int b = 0; b < 3; b++) begin
            c_in_data   = F_TWO;
            c_in_weight = F_THR;
            c_bias      = (b == 0) ? F_ONE : F_TEN;
            c_in_valid  = 1'b1;
            @(negedge clk);
            check1("c_in_ready", c_in_ready, 1'b1);
            @(posedge clk);
            #1;
            c_in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check1("c_valid_early", c_out_valid, 1'b0);
        @(posedge clk);
        #1;
        check1("c_valid_latency", c_out_valid, 1'b1);
        @(posedge clk);
        #1;
        check1("c_valid_cleared", c_out_valid, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("pending_a", 32'(exp_a.size()), 32'd0);
        check("pending_b", 32'(exp_b.size()), 32'd0);
        check("pending_c", 32'(exp_c.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
